manchester_frame_rx: RTL and testbench

- Receives the Manchester-coded counter readout stream: data XOR bit clock, MSB first, 4-bit header 1010 followed by a COUNTER_LENGTH-bit count.
- Runs on a board-side or test-harness clock that oversamples the stream, recovers bit timing from the edges, checks the header, and presents each decoded counter value with a one-cycle valid pulse.
- Used in the verification harness and in companion FPGA readout logic.

---
 rtl/manchester_frame_rx.sv | 160 ++++++++++++++++
 tb/tb_manchester_frame_rx.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_frame_rx.sv
// Oversampling Manchester frame receiver: header 1010 followed by a COUNTER_LENGTH-bit count, MSB first.
// Optional MANCHESTER_RX_GLITCH_FILTER_EN inserts a 3-sample majority filter ahead of edge detection.
module manchester_frame_rx #(
  parameter int COUNTER_LENGTH  = 20,
  parameter int HALF_BIT_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      rx_in,
  output logic [COUNTER_LENGTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      frame_error,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  localparam int FRAME_BITS = COUNTER_LENGTH + 4;
  localparam int BC_W       = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] LO       = CNT_W'(3 * HALF_BIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] HI       = CNT_W'(5 * HALF_BIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BC_W-1:0]  HDR_LAST   = BC_W'(3);
  localparam logic [BC_W-1:0]  FRAME_LAST = BC_W'(FRAME_BITS - 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Output protocol: data_valid and frame_error are one-cycle strobes with no
  // ready/back-pressure; the consumer must capture data_out on the data_valid cycle.

  logic sync_meta;
  logic sync_level;
  logic prev_level;
  logic level_after;
  logic edge_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      prev_level <= 1'b0;
    end else begin
      sync_meta  <= rx_in;
      sync_level <= sync_meta;
      prev_level <= level_after;
    end
  end

`ifdef MANCHESTER_RX_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
    end else begin
      hist1 <= sync_level;
      hist2 <= hist1;
    end
  end

  // Majority of the last three synchronized samples; a lone odd sample never wins.
  assign level_after = (sync_level & hist1) | (sync_level & hist2) | (hist1 & hist2);
`else
  assign level_after = sync_level;
`endif

  assign edge_det = (level_after != prev_level);

  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_inc;
  logic [BC_W-1:0]           bit_cnt;
  logic [COUNTER_LENGTH-1:0] shreg;
  logic                      mid_window;
  logic                      header_ok;

  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign mid_window = edge_det && (cnt >= LO) && (cnt <= HI);
  // The first three header bits are still in the low end of shreg when the fourth arrives.
  assign header_ok  = ({shreg[2:0], level_after} == 4'b1010);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (!ena) begin
        state   <= ST_HUNT;
        cnt     <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_HUNT: begin
            if (edge_det) begin
              cnt <= '0;
              // A rising edge after a two-half-bit low can only be the mid-bit of a '1'.
              if (level_after && mid_window) begin
                shreg   <= COUNTER_LENGTH'(1);
                bit_cnt <= BC_W'(1);
                state   <= ST_RECEIVE;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_RECEIVE: begin
            if (mid_window) begin
              shreg   <= {shreg[COUNTER_LENGTH-2:0], level_after};
              bit_cnt <= bit_cnt + 1'b1;
              cnt     <= '0;
              if (bit_cnt == HDR_LAST && !header_ok) begin
                frame_error <= 1'b1;
                state       <= ST_HUNT;
                bit_cnt     <= '0;
              end else if (bit_cnt == FRAME_LAST) begin
                state <= ST_DONE;
              end
            end else if (cnt > HI) begin
              frame_error <= 1'b1;
              state       <= ST_HUNT;
              bit_cnt     <= '0;
              cnt         <= cnt_inc;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_DONE: begin
            data_out   <= shreg;
            data_valid <= 1'b1;
            state      <= ST_HUNT;
            bit_cnt    <= '0;
            cnt        <= edge_det ? '0 : cnt_inc;
          end
          default: begin
            state   <= ST_HUNT;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign busy      = (state == ST_RECEIVE);
  assign state_dbg = state;

endmodule

// File: tb/tb_manchester_frame_rx.sv
// Self-checking bench for manchester_frame_rx: random payloads and half-bit jitter, scored
// against a queue of expected payloads and their expected data_valid cycle.
module tb_manchester_frame_rx;

  localparam int N = 20;
  localparam int H = 8;
`ifdef MANCHESTER_RX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         rx_in;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         frame_error;
  logic         busy;
  logic [1:0]   state_dbg;

  manchester_frame_rx #(
    .COUNTER_LENGTH (N),
    .HALF_BIT_CYCLES(H),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor (records only) ----------------
  logic [N-1:0] got_q[$];
  int           got_cyc_q[$];
  int           fe_cyc_q[$];
  int           both_count = 0;

  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back(data_out);
      got_cyc_q.push_back(cyc);
    end
    if (frame_error) fe_cyc_q.push_back(cyc);
    if (data_valid && frame_error) both_count <= both_count + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [N-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           got_rd = 0;
  int           exp_rd = 0;
  logic [N-1:0] last_good = '0;
  int           checks = 0;
  int           errors = 0;

  // ---------------- drivers ----------------
  int jit_mode = 0;
  bit alt = 1'b0;
  int last_mid_cyc = 0;
  int hdr_mid_cyc = 0;

  task automatic next_half(output int n);
    case (jit_mode)
      0:       n = H;
      1:       begin n = alt ? H + 1 : H - 1; alt = !alt; end
      default: n = int'($urandom_range(H + 1, H - 1));
    endcase
  endtask

  task automatic drive_half(input logic lvl, input int n);
    rx_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Manchester bit b = data XOR bit clock: first half ~b, second half b.
  task automatic drive_bit(input logic b, input bit glitch);
    int n;
    if (glitch) begin
      drive_half(~b, 4);
      drive_half(b, 1);
      drive_half(~b, 3);
      last_mid_cyc = cyc;
      drive_half(b, H);
    end else begin
      next_half(n);
      drive_half(~b, n);
      last_mid_cyc = cyc;
      next_half(n);
      drive_half(b, n);
    end
  endtask

  task automatic drive_idle(input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(1'b0, 1'b0);
  endtask

  task automatic drive_frame(input logic [3:0] hdr, input logic [N-1:0] pay,
                             input int nbits, input int glitch_bit);
    logic [N+3:0] fw;
    fw = {hdr, pay};
    for (int i = 0; i < nbits; i++) begin
      drive_bit(fw[N+3-i], i == glitch_bit);
      if (i == 3) hdr_mid_cyc = last_mid_cyc;
    end
  endtask

  // Good frame: the model expects the payload LAT cycles after the final mid-bit transition.
  task automatic send_good(input logic [N-1:0] pay);
    drive_frame(4'b1010, pay, N + 4, -1);
    exp_q.push_back(pay);
    exp_cyc_q.push_back(last_mid_cyc + LAT);
    last_good = pay;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    ena   = 1'b1;
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h exp 0", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b exp 0", data_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b exp 0", frame_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_basic;
    int fe0;
    jit_mode = 0;
    fe0 = fe_cyc_q.size();
    drive_idle(40);
    send_good(20'hA5C3F);
    drive_idle(3);
    checks++; if (got_q.size() - got_rd !== 1) begin errors++; $display("FAIL basic_dv_count got %0d exp 1", got_q.size() - got_rd); end
    checks++; if (fe_cyc_q.size() !== fe0) begin errors++; $display("FAIL basic_fe_count got %0d exp 0", fe_cyc_q.size() - fe0); end
    for (; got_rd < got_q.size(); got_rd++) begin
      checks++;
      if (exp_rd >= exp_q.size()) begin errors++; $display("FAIL basic_extra got %h", got_q[got_rd]); end
      else begin
        if (got_q[got_rd] !== exp_q[exp_rd] || got_cyc_q[got_rd] !== exp_cyc_q[exp_rd]) begin
          errors++; $display("FAIL basic_data got %h@%0d exp %h@%0d", got_q[got_rd], got_cyc_q[got_rd], exp_q[exp_rd], exp_cyc_q[exp_rd]);
        end
        exp_rd++;
      end
    end
  endtask

  task automatic test_bad_header;
    int dv0, fe0, d;
    jit_mode = 0;
    dv0 = got_q.size();
    fe0 = fe_cyc_q.size();
    drive_idle(6);
    drive_frame(4'b1110, 20'hFFFFF, N + 4, -1);
    drive_idle(4);
    checks++; if (got_q.size() !== dv0) begin errors++; $display("FAIL hdr_no_valid got %0d exp 0", got_q.size() - dv0); end
    checks++;
    if (fe_cyc_q.size() <= fe0) begin errors++; $display("FAIL hdr_error got 0 pulses exp >=1"); end
    else begin
      d = fe_cyc_q[fe0] - hdr_mid_cyc;
      checks++; if (d < 1 || d > LAT + 2) begin errors++; $display("FAIL hdr_error_time got %0d exp 1..%0d", d, LAT + 2); end
    end
    checks++; if (data_out !== last_good) begin errors++; $display("FAIL hdr_data_hold got %h exp %h", data_out, last_good); end
    got_rd = got_q.size();
  endtask

  task automatic test_jitter_back_to_back;
    int fe0;
    jit_mode = 1;
    fe0 = fe_cyc_q.size();
    drive_idle(8);
    send_good(20'hFFFFF);
    drive_idle(1);
    send_good(20'h00001);
    drive_idle(3);
    checks++; if (got_q.size() - got_rd !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d exp 2", got_q.size() - got_rd); end
    checks++; if (fe_cyc_q.size() !== fe0) begin errors++; $display("FAIL b2b_fe_count got %0d exp 0", fe_cyc_q.size() - fe0); end
    for (; got_rd < got_q.size(); got_rd++) begin
      checks++;
      if (exp_rd >= exp_q.size()) begin errors++; $display("FAIL b2b_extra got %h", got_q[got_rd]); end
      else begin
        if (got_q[got_rd] !== exp_q[exp_rd] || got_cyc_q[got_rd] !== exp_cyc_q[exp_rd]) begin
          errors++; $display("FAIL b2b_data got %h@%0d exp %h@%0d", got_q[got_rd], got_cyc_q[got_rd], exp_q[exp_rd], exp_cyc_q[exp_rd]);
        end
        exp_rd++;
      end
    end
  endtask

  task automatic test_timeout;
    int fe0, d;
    jit_mode = 0;
    fe0 = fe_cyc_q.size();
    drive_idle(4);
    drive_frame(4'b1010, N'($urandom), 14, -1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy got %b exp 1", busy); end
    repeat (40) @(negedge clk);
    checks++;
    if (fe_cyc_q.size() - fe0 !== 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", fe_cyc_q.size() - fe0); end
    else begin
      d = fe_cyc_q[fe0] - last_mid_cyc;
      checks++; if (d < 20 || d > 30) begin errors++; $display("FAIL timeout_time got %0d exp 20..30", d); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_clear got %b exp 0", busy); end
    drive_idle(4);
    send_good(20'h12345);
    drive_idle(3);
    checks++; if (got_q.size() - got_rd !== 1) begin errors++; $display("FAIL timeout_recover_count got %0d exp 1", got_q.size() - got_rd); end
    for (; got_rd < got_q.size(); got_rd++) begin
      checks++;
      if (exp_rd >= exp_q.size()) begin errors++; $display("FAIL timeout_extra got %h", got_q[got_rd]); end
      else begin
        if (got_q[got_rd] !== exp_q[exp_rd] || got_cyc_q[got_rd] !== exp_cyc_q[exp_rd]) begin
          errors++; $display("FAIL timeout_data got %h@%0d exp %h@%0d", got_q[got_rd], got_cyc_q[got_rd], exp_q[exp_rd], exp_cyc_q[exp_rd]);
        end
        exp_rd++;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    jit_mode = 0;
    drive_idle(4);
    drive_frame(4'b1010, N'($urandom), 12, -1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", busy); end
    #2 rst_n = 1'b0;
    rx_in = 1'b0;
    #1;
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rstmid_data_out got %h exp 0", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_clear got %b exp 0", busy); end
    checks++; if (data_valid !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL rstmid_pulses got %b%b exp 00", data_valid, frame_error); end
    last_good = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    drive_idle(4);
    send_good(N'($urandom));
    drive_idle(3);
    checks++; if (got_q.size() - got_rd !== 1) begin errors++; $display("FAIL rstmid_recover_count got %0d exp 1", got_q.size() - got_rd); end
    for (; got_rd < got_q.size(); got_rd++) begin
      checks++;
      if (exp_rd >= exp_q.size()) begin errors++; $display("FAIL rstmid_extra got %h", got_q[got_rd]); end
      else begin
        if (got_q[got_rd] !== exp_q[exp_rd] || got_cyc_q[got_rd] !== exp_cyc_q[exp_rd]) begin
          errors++; $display("FAIL rstmid_data got %h@%0d exp %h@%0d", got_q[got_rd], got_cyc_q[got_rd], exp_q[exp_rd], exp_cyc_q[exp_rd]);
        end
        exp_rd++;
      end
    end
  endtask

  task automatic test_ena_abort;
    int dv0, fe0;
    jit_mode = 0;
    dv0 = got_q.size();
    fe0 = fe_cyc_q.size();
    drive_idle(4);
    drive_frame(4'b1010, N'($urandom), 10, -1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ena_busy got %b exp 1", busy); end
    ena = 1'b0;
    drive_idle(3);
    ena = 1'b1;
    drive_idle(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_busy_clear got %b exp 0", busy); end
    checks++; if (fe_cyc_q.size() !== fe0) begin errors++; $display("FAIL ena_no_error got %0d exp 0", fe_cyc_q.size() - fe0); end
    checks++; if (got_q.size() !== dv0) begin errors++; $display("FAIL ena_no_valid got %0d exp 0", got_q.size() - dv0); end
    checks++; if (data_out !== last_good) begin errors++; $display("FAIL ena_data_hold got %h exp %h", data_out, last_good); end
  endtask

  task automatic test_glitch;
    int fe0;
    jit_mode = 0;
    fe0 = fe_cyc_q.size();
    drive_idle(8);
    // One-cycle glitch in the middle of the first half of header bit 1.
    drive_frame(4'b1010, 20'h0F0F0, N + 4, 1);
`ifdef MANCHESTER_RX_GLITCH_FILTER_EN
    exp_q.push_back(20'h0F0F0);
    exp_cyc_q.push_back(last_mid_cyc + LAT);
    last_good = 20'h0F0F0;
    drive_idle(3);
    checks++; if (got_q.size() - got_rd !== 1) begin errors++; $display("FAIL glitch_dv_count got %0d exp 1", got_q.size() - got_rd); end
    checks++; if (fe_cyc_q.size() !== fe0) begin errors++; $display("FAIL glitch_fe_count got %0d exp 0", fe_cyc_q.size() - fe0); end
`else
    drive_idle(3);
    checks++; if (got_q.size() !== got_rd) begin errors++; $display("FAIL glitch_no_valid got %0d exp 0", got_q.size() - got_rd); end
    checks++; if (fe_cyc_q.size() <= fe0) begin errors++; $display("FAIL glitch_error got 0 pulses exp >=1"); end
    checks++; if (data_out !== last_good) begin errors++; $display("FAIL glitch_data_hold got %h exp %h", data_out, last_good); end
`endif
    for (; got_rd < got_q.size(); got_rd++) begin
      checks++;
      if (exp_rd >= exp_q.size()) begin errors++; $display("FAIL glitch_extra got %h", got_q[got_rd]); end
      else begin
        if (got_q[got_rd] !== exp_q[exp_rd] || got_cyc_q[got_rd] !== exp_cyc_q[exp_rd]) begin
          errors++; $display("FAIL glitch_data got %h@%0d exp %h@%0d", got_q[got_rd], got_cyc_q[got_rd], exp_q[exp_rd], exp_cyc_q[exp_rd]);
        end
        exp_rd++;
      end
    end
  endtask

  task automatic test_random;
    int fe0, n0;
    jit_mode = 2;
    fe0 = fe_cyc_q.size();
    n0 = got_q.size();
    drive_idle(4);
    for (int f = 0; f < 6; f++) begin
      send_good(N'($urandom));
      drive_idle(int'($urandom_range(3, 1)));
    end
    drive_idle(2);
    checks++; if (got_q.size() - n0 !== 6) begin errors++; $display("FAIL random_dv_count got %0d exp 6", got_q.size() - n0); end
    checks++; if (fe_cyc_q.size() !== fe0) begin errors++; $display("FAIL random_fe_count got %0d exp 0", fe_cyc_q.size() - fe0); end
    for (; got_rd < got_q.size(); got_rd++) begin
      checks++;
      if (exp_rd >= exp_q.size()) begin errors++; $display("FAIL random_extra got %h", got_q[got_rd]); end
      else begin
        if (got_q[got_rd] !== exp_q[exp_rd] || got_cyc_q[got_rd] !== exp_cyc_q[exp_rd]) begin
          errors++; $display("FAIL random_data got %h@%0d exp %h@%0d", got_q[got_rd], got_cyc_q[got_rd], exp_q[exp_rd], exp_cyc_q[exp_rd]);
        end
        exp_rd++;
      end
    end
  endtask

  task automatic test_exclusive;
    checks++; if (both_count !== 0) begin errors++; $display("FAIL valid_error_overlap got %0d exp 0", both_count); end
    checks++; if (exp_rd !== exp_q.size()) begin errors++; $display("FAIL missing_frames got %0d exp %0d", exp_rd, exp_q.size()); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_jitter_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_ena_abort();
    test_glitch();
    test_random();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
